// File: rtl/spart_driver.sv
// Processor-side SPART bus master: programs the baud divisor, then echoes received bytes
// back to the transmitter through a small FIFO.
module spart_driver #(
  parameter logic [15:0] DIV_4800   = 16'h028A,
  parameter logic [15:0] DIV_9600   = 16'h0145,
  parameter logic [15:0] DIV_19200  = 16'h00A2,
  parameter logic [15:0] DIV_38400  = 16'h0050,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  input  logic                          rda,
  input  logic                          tbr,
  output logic                          iocs,
  output logic                          iorw,
  output logic [1:0]                    ioaddr,
  inout  wire  [7:0]                    databus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    INIT_LO,
    INIT_HI,
    IDLE,
    RD_RX,
    WR_TX,
    GAP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_iocs;
  logic            r_iorw;
  logic [1:0]      r_ioaddr;
  logic [7:0]      r_dout;
  logic [1:0]      r_shadow;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_cnt;

  logic            w_iocs;
  logic            w_iorw;
  logic [1:0]      w_ioaddr;
  logic [7:0]      w_dout;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [15:0]     w_div_cfg;
  logic [15:0]     w_div_shadow;

  function automatic logic [15:0] f_div(input logic [1:0] sel);
    case (sel)
      2'b00:   return DIV_4800;
      2'b01:   return DIV_9600;
      2'b10:   return DIV_19200;
      default: return DIV_38400;
    endcase
  endfunction

  // The low byte is registered on the same edge the shadow loads, so it uses br_cfg directly.
  assign w_div_cfg    = f_div(br_cfg);
  assign w_div_shadow = f_div(r_shadow);
  assign w_full       = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty      = (r_cnt == '0);

  // Bus outputs lag the state by one cycle: the strobe for a state appears while the FSM
  // already sits in its successor, and the strobe cycle's end is where data moves.
  assign w_push = r_iocs & r_iorw;
  assign w_pop  = r_iocs & ~r_iorw & (r_ioaddr == 2'b00);

  always_comb begin
    w_next   = r_state;
    w_iocs   = 1'b0;
    w_iorw   = 1'b1;
    w_ioaddr = 2'b00;
    w_dout   = r_dout;
    unique case (r_state)
      INIT_LO: begin
        w_next   = INIT_HI;
        w_iocs   = 1'b1;
        w_iorw   = 1'b0;
        w_ioaddr = 2'b10;
        w_dout   = w_div_cfg[7:0];
      end
      INIT_HI: begin
        w_next   = GAP;
        w_iocs   = 1'b1;
        w_iorw   = 1'b0;
        w_ioaddr = 2'b11;
        w_dout   = w_div_shadow[15:8];
      end
      IDLE: begin
        if (br_cfg != r_shadow)   w_next = INIT_LO;
        else if (rda && !w_full)  w_next = RD_RX;
        else if (tbr && !w_empty) w_next = WR_TX;
      end
      RD_RX: begin
        w_next = GAP;
        w_iocs = 1'b1;
      end
      WR_TX: begin
        w_next = GAP;
        w_iocs = 1'b1;
        w_iorw = 1'b0;
        w_dout = r_mem[r_rd_ptr];
      end
      GAP:     w_next = IDLE;
      default: w_next = INIT_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= INIT_LO;
      r_iocs   <= 1'b0;
      r_iorw   <= 1'b1;
      r_ioaddr <= 2'b00;
      r_dout   <= '0;
      r_shadow <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next;
      r_iocs   <= w_iocs;
      r_iorw   <= w_iorw;
      r_ioaddr <= w_ioaddr;
      r_dout   <= w_dout;
      if (r_state == INIT_LO) r_shadow <= br_cfg;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_cnt    <= r_cnt + 1'b1;
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_cnt    <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= databus;
  end

  assign databus  = (r_iocs && !r_iorw) ? r_dout : 'z;
  assign iocs     = r_iocs;
  assign iorw     = r_iorw;
  assign ioaddr   = r_ioaddr;
  assign fifo_cnt = r_cnt;

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver: a SPART-side bus model plus a transaction-level
// reference that predicts each bus strobe from the rx/tx priority rules.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [2:0] fifo_cnt;

  always #5 clk = ~clk;

  spart_driver #(
    .DIV_4800  (16'h028A),
    .DIV_9600  (16'h0145),
    .DIV_19200 (16'h00A2),
    .DIV_38400 (16'h0050),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .br_cfg  (br_cfg),
    .rda     (rda),
    .tbr     (tbr),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .fifo_cnt(fifo_cnt)
  );

  // SPART receive side: bytes waiting to be read, consumed at the edge ending a read strobe.
  logic [7:0] rx_mem [0:63];
  int         rx_wr = 0;
  int         rx_rd = 0;

  assign rda     = (rx_rd != rx_wr);
  assign databus = (iocs && iorw) ? rx_mem[rx_rd] : 8'bzzzzzzzz;

  always @(posedge clk) begin
    if (iocs && iorw && ioaddr == 2'b00 && rx_rd != rx_wr) rx_rd <= rx_rd + 1;
  end

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] ref_rx   [$];
  logic [7:0] ref_fifo [$];

  function automatic logic [15:0] div_of(input logic [1:0] cfg);
    case (cfg)
      2'b00:   return 16'h028A;
      2'b01:   return 16'h0145;
      2'b10:   return 16'h00A2;
      default: return 16'h0050;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [7:0] b);
    rx_mem[rx_wr] = b;
    rx_wr++;
    ref_rx.push_back(b);
  endtask

  task automatic wait_iocs(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (iocs === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, " strobe_seen"}, 16'(ok), 16'd1);
  endtask

  // Predict the next strobe: a pending rx byte wins while the queue has room, else a tx write.
  task automatic next_txn(input string tag);
    bit         ok;
    logic       exp_rd;
    logic [7:0] exp_d;
    if (ref_rx.size() > 0 && ref_fifo.size() < 4) begin
      exp_rd = 1'b1;
      exp_d  = ref_rx[0];
    end else begin
      exp_rd = 1'b0;
      exp_d  = (ref_fifo.size() > 0) ? ref_fifo[0] : 8'h00;
    end
    wait_iocs(tag, ok);
    if (ok) begin
      check({tag, " iorw"}, 16'(iorw), 16'(exp_rd));
      check({tag, " ioaddr"}, 16'(ioaddr), 16'd0);
      check({tag, " data"}, 16'(databus), 16'(exp_d));
      if (exp_rd) ref_fifo.push_back(ref_rx.pop_front());
      else if (ref_fifo.size() > 0) void'(ref_fifo.pop_front());
      @(negedge clk);
      check({tag, " fifo_cnt"}, 16'(fifo_cnt), 16'(ref_fifo.size()));
    end
  endtask

  task automatic check_init(input string tag, input logic [1:0] cfg);
    bit          ok;
    logic [15:0] d;
    d = div_of(cfg);
    wait_iocs(tag, ok);
    if (ok) begin
      check({tag, " lo_iorw"}, 16'(iorw), 16'd0);
      check({tag, " lo_addr"}, 16'(ioaddr), 16'd2);
      check({tag, " lo_data"}, 16'(databus), 16'(d[7:0]));
      @(negedge clk);
      check({tag, " hi_iocs"}, 16'(iocs), 16'd1);
      check({tag, " hi_iorw"}, 16'(iorw), 16'd0);
      check({tag, " hi_addr"}, 16'(ioaddr), 16'd3);
      check({tag, " hi_data"}, 16'(databus), 16'(d[15:8]));
      @(negedge clk);
      check({tag, " after_iocs"}, 16'(iocs), 16'd0);
    end
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (iocs !== 1'b0) seen++;
    end
    check({tag, " strobes"}, 16'(seen), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    rst    = 1'b1;
    tbr    = 1'b0;
    br_cfg = 2'b01;

    for (int i = 0; i < 3; i++) @(negedge clk);
    check("reset iocs", 16'(iocs), 16'd0);
    check("reset iorw", 16'(iorw), 16'd1);
    check("reset ioaddr", 16'(ioaddr), 16'd0);
    check("reset fifo_cnt", 16'(fifo_cnt), 16'd0);
    rst = 1'b0;

    check_init("init01", 2'b01);

    // Single echo with tbr already high.
    tbr = 1'b1;
    offer(8'hA5);
    next_txn("echo_rd");
    next_txn("echo_wr");

    // Fill the queue while tx is blocked; the fifth byte must wait in the SPART.
    tbr = 1'b0;
    for (int i = 0; i < 5; i++) offer(8'($urandom));
    for (int i = 0; i < 4; i++) next_txn("fill");
    check("full fifo_cnt", 16'(fifo_cnt), 16'd4);
    expect_quiet("full_hold", 12);
    tbr = 1'b1;
    for (int i = 0; i < 6; i++) next_txn("drain");
    check("drain rda", 16'(rda), 16'd0);

    // rda and tbr together with one byte queued.
    tbr = 1'b0;
    offer(8'($urandom));
    next_txn("prio_pre");
    tbr = 1'b1;
    offer(8'($urandom));
    next_txn("prio_both");
    next_txn("prio_wr1");
    next_txn("prio_wr2");

    // Random burst with tx open; ordering follows the priority rules.
    n = int'($urandom_range(8, 2));
    for (int i = 0; i < n; i++) offer(8'($urandom));
    for (int i = 0; i < 2 * n; i++) next_txn("burst");
    check("burst fifo_cnt", 16'(fifo_cnt), 16'd0);

    // Reprogram while holding queued bytes.
    tbr = 1'b0;
    offer(8'($urandom));
    offer(8'($urandom));
    next_txn("pre_cfg1");
    next_txn("pre_cfg2");
    br_cfg = 2'b11;
    check_init("reinit11", 2'b11);
    check("reinit fifo_cnt", 16'(fifo_cnt), 16'd2);

    // Reset landing on a write strobe.
    tbr = 1'b1;
    wait_iocs("rst_wr", ok);
    if (ok) begin
      check("rst_wr iorw", 16'(iorw), 16'd0);
      check("rst_wr data", 16'(databus), 16'(ref_fifo[0]));
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid iocs", 16'(iocs), 16'd0);
      check("rst_mid iorw", 16'(iorw), 16'd1);
      check("rst_mid fifo_cnt", 16'(fifo_cnt), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      ref_fifo.delete();
      check_init("replay", 2'b11);
      expect_quiet("post_replay", 6);
      check("post_replay fifo_cnt", 16'(fifo_cnt), 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
